spi_lcd_init_ctrl: RTL and testbench
====================================

SPI_LCD_INIT_CTRL -- requirements
Module: spi_lcd_init_ctrl

Interface
REQ-001 SHALL have parameter NumEntries, default 32, giving the init-table depth (1..256).
REQ-002 SHALL have parameter RstCycles, default 1000, giving the LCD hardware-reset low time in clk_sys_i cycles.
REQ-003 SHALL have parameter DelayUnit, default 50000, giving the number of cycles per DELAY argument unit.
REQ-004 SHALL have port clk_sys_i, input, 1 bit: the system clock, which is the only clock in the block.
REQ-005 SHALL have port rst_sys_ni, input, 1 bit: the reset, which is synchronous and active-low.
REQ-006 SHALL have port start_i, input, 1 bit: a pulse that starts the init sequence.
REQ-007 SHALL have port tbl_addr_o, output, 8 bits: the init-table index.
REQ-008 SHALL have port tbl_entry_i, input, 10 bits: {op[1:0], arg[7:0]}, returned combinationally for tbl_addr_o.
REQ-009 SHALL have port cpu_valid_i, input, 1 bit: CPU byte request.
REQ-010 SHALL have port cpu_data_i, input, 8 bits: CPU byte.
REQ-011 SHALL have port cpu_dc_i, input, 1 bit: CPU data/command select.
REQ-012 SHALL have port cpu_ready_o, output, 1 bit: CPU byte accepted.
REQ-013 SHALL have port spi_valid_o, input-side handshake to the SPI host: output, 1 bit, byte valid.
REQ-014 SHALL have port spi_data_o, output, 8 bits: byte to the SPI host.
REQ-015 SHALL have port spi_ready_i, input, 1 bit: SPI host accepts the byte.
REQ-016 SHALL have port spi_idle_i, input, 1 bit: SPI host shifter is empty.
REQ-017 SHALL have port lcd_dc_o, output, 1 bit: LCD D/C line (0 = command).
REQ-018 SHALL have port lcd_rst_no, output, 1 bit: LCD hardware reset, active-low.
REQ-019 SHALL have port busy_o, output, 1 bit: sequence in progress.
REQ-020 SHALL have port done_o, output, 1 bit: init complete, CPU owns the SPI.

Function
REQ-021 SHALL implement an FSM with states IDLE, RST_LOW, RST_WAIT, FETCH, SEND, DRAIN, DELAY and PASS.
REQ-022 In IDLE, start_i SHALL cause a transition to RST_LOW, clear the index to 0, and assert busy_o on the next cycle.
REQ-023 RST_LOW SHALL drive lcd_rst_no=0 for exactly RstCycles cycles and then go to RST_WAIT.
REQ-024 RST_WAIT SHALL hold lcd_rst_no=1 for RstCycles cycles and then go to FETCH.
REQ-025 FETCH SHALL decode tbl_entry_i in one cycle: op 0 = CMD, op 1 = DATA, op 2 = DELAY, op 3 = END.
REQ-026 For CMD and DATA, the block SHALL latch arg and set dc (0 for CMD, 1 for DATA), then enter SEND.
REQ-027 SEND SHALL hold spi_valid_o=1 with stable data and dc until spi_ready_i, then increment the index and return to FETCH.
REQ-028 A CMD entry SHALL first enter DRAIN, waiting for spi_idle_i=1 before changing lcd_dc_o, so that D/C never toggles mid-byte.
REQ-029 DELAY SHALL wait arg*DelayUnit cycles (arg=0 is one cycle), then increment the index and go to FETCH; the counter SHALL be 32 bits.
REQ-030 END, or index reaching NumEntries, SHALL trigger DRAIN and then PASS with done_o=1 and busy_o=0.
REQ-031 In PASS, spi_valid_o, spi_data_o and lcd_dc_o SHALL follow cpu_valid_i, cpu_data_i and cpu_dc_i combinationally, and cpu_ready_o SHALL equal spi_ready_i.
REQ-032 Outside PASS, cpu_ready_o SHALL be 0, and CPU requests SHALL be held off without being dropped.
REQ-033 start_i in PASS SHALL restart the sequence (RST_LOW), clearing done_o next cycle; start_i is ignored in all other states.
REQ-034 The index SHALL never wrap: NumEntries-1 is the last entry fetched.

Reset
REQ-035 Reset SHALL set the state to IDLE, spi_valid_o=0, spi_data_o=0, lcd_dc_o=0, lcd_rst_no=1, cpu_ready_o=0, busy_o=0, done_o=0, tbl_addr_o=0, and clear all counters.
REQ-036 Reset asserted mid-sequence, including during SEND, SHALL abandon the byte immediately; the SPI host is reset by the same signal.

Structure
REQ-037 Op encodings, the FSM state enum and the entry typedef SHALL live in a shared package, spi_lcd_pkg.
REQ-038 A single sub-module, spi_lcd_init_rom (table indexed by tbl_addr_o), SHALL be instantiated alongside the block, not inside it.

Verification
REQ-039 With RstCycles=4, a start_i pulse SHALL produce lcd_rst_no low for exactly 4 cycles, then high for 4, then the first FETCH.
REQ-040 Table {CMD 0x11, DATA 0x05, END} with spi_ready_i stalled 3 cycles SHALL hold bytes 0x11 (dc=0) and 0x05 (dc=1) stable, with lcd_dc_o changing only after spi_idle_i.
REQ-041 DELAY arg=3 with DelayUnit=10 SHALL leave exactly 30 cycles between the adjacent byte handshakes (±FSM overhead, stated exactly by the bench).
REQ-042 cpu_valid_i held during init SHALL see cpu_ready_o=0 until done_o, after which CPU byte 0xA5 SHALL pass through in the same cycle.
REQ-043 Reset asserted during SEND SHALL return all outputs to reset values on the next edge, and a new start_i SHALL rerun the sequence from index 0.
REQ-044 A table with no END and NumEntries=2 SHALL send 2 bytes and then enter PASS, with tbl_addr_o never exceeding 1.

Source files
------------

// File: rtl/spi_lcd_pkg.sv
// Shared types for the SPI LCD init controller: op codes, table entry, FSM states.
package spi_lcd_pkg;

  localparam int unsigned EntryW = 10;

  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_DATA  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] arg;
  } tbl_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_WAIT,
    FETCH,
    SEND,
    DRAIN,
    DELAY,
    PASS
  } state_e;

  // Build one init-table entry; keeps tables readable at the instantiation site.
  function automatic tbl_entry_t mk_entry(input op_e op, input logic [7:0] arg);
    tbl_entry_t e;
    e.op  = op;
    e.arg = arg;
    return e;
  endfunction

endpackage

// File: rtl/spi_lcd_init_rom.sv
// Init table: combinational lookup, addresses past the table read as CMD 0x00.
module spi_lcd_init_rom
  import spi_lcd_pkg::*;
#(
  parameter int unsigned                 NumEntries = 32,
  parameter tbl_entry_t [NumEntries-1:0] Table      = '0
) (
  input  logic [7:0]        tbl_addr_i,
  output logic [EntryW-1:0] tbl_entry_o
);

  // Address decode by compare so the index width never depends on NumEntries.
  always_comb begin
    tbl_entry_o = '0;
    for (int unsigned i = 0; i < NumEntries; i++) begin
      if (tbl_addr_i == 8'(i)) tbl_entry_o = Table[i];
    end
  end

endmodule

// File: rtl/spi_lcd_init_ctrl.sv
// LCD power-on sequencer: pulses hardware reset, plays an init table over SPI,
// then hands the SPI byte channel to the CPU.
module spi_lcd_init_ctrl
  import spi_lcd_pkg::*;
#(
  parameter int unsigned NumEntries = 32,
  parameter int unsigned RstCycles  = 1000,
  parameter int unsigned DelayUnit  = 50000
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_ni,
  input  logic              start_i,
  output logic [7:0]        tbl_addr_o,
  input  logic [EntryW-1:0] tbl_entry_i,
  input  logic              cpu_valid_i,
  input  logic [7:0]        cpu_data_i,
  input  logic              cpu_dc_i,
  output logic              cpu_ready_o,
  output logic              spi_valid_o,
  output logic [7:0]        spi_data_o,
  input  logic              spi_ready_i,
  input  logic              spi_idle_i,
  output logic              lcd_dc_o,
  output logic              lcd_rst_no,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [7:0]  LastIdx = 8'(NumEntries - 1);
  localparam logic [31:0] RstLast = 32'(RstCycles - 1);

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dly_lim_q, dly_lim_d;
  logic [7:0] data_q, data_d;
  logic       dc_q, dc_d;
  logic       pend_dc_q, pend_dc_d;  // D/C level to apply once the shifter drains
  logic       end_q, end_d;          // DRAIN exits to PASS instead of SEND
  tbl_entry_t entry;

  assign entry = tbl_entry_i;

  // Next-state and datapath updates; index saturates at the last entry.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dly_lim_d = dly_lim_q;
    data_d    = data_q;
    dc_d      = dc_q;
    pend_dc_d = pend_dc_q;
    end_d     = end_q;
    case (state_q)
      IDLE, PASS: begin
        if (start_i) begin
          state_d = RST_LOW;
          idx_d   = '0;
          cnt_d   = '0;
          end_d   = 1'b0;
        end
      end
      RST_LOW: begin
        if (cnt_q == RstLast) begin
          cnt_d   = '0;
          state_d = RST_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RST_WAIT: begin
        if (cnt_q == RstLast) begin
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      FETCH: begin
        case (entry.op)
          OP_CMD: begin
            data_d    = entry.arg;
            pend_dc_d = 1'b0;
            state_d   = DRAIN;
          end
          OP_DATA: begin
            // Data after a command also flips D/C, so it must drain first too.
            data_d    = entry.arg;
            pend_dc_d = 1'b1;
            state_d   = dc_q ? SEND : DRAIN;
          end
          OP_DELAY: begin
            cnt_d     = '0;
            dly_lim_d = (entry.arg == 8'd0) ? 32'd1 : 32'(entry.arg) * 32'(DelayUnit);
            state_d   = DELAY;
          end
          default: begin
            end_d   = 1'b1;
            state_d = DRAIN;
          end
        endcase
      end
      SEND: begin
        if (spi_ready_i) begin
          if (idx_q == LastIdx) begin
            end_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = FETCH;
          end
        end
      end
      DELAY: begin
        if (cnt_q == dly_lim_q - 32'd1) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            end_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DRAIN: begin
        if (spi_idle_i) begin
          if (end_q) begin
            state_d = PASS;
          end else begin
            dc_d    = pend_dc_q;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      dly_lim_q <= '0;
      data_q    <= '0;
      dc_q      <= 1'b0;
      pend_dc_q <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dly_lim_q <= dly_lim_d;
      data_q    <= data_d;
      dc_q      <= dc_d;
      pend_dc_q <= pend_dc_d;
      end_q     <= end_d;
    end
  end

  // SPI/LCD outputs: sequencer-owned until PASS, then a straight CPU bypass.
  always_comb begin
    spi_valid_o = (state_q == SEND);
    spi_data_o  = data_q;
    lcd_dc_o    = dc_q;
    cpu_ready_o = 1'b0;
    if (state_q == PASS) begin
      spi_valid_o = cpu_valid_i;
      spi_data_o  = cpu_data_i;
      lcd_dc_o    = cpu_dc_i;
      cpu_ready_o = spi_ready_i;
    end
  end

  assign tbl_addr_o = idx_q;
  assign lcd_rst_no = (state_q != RST_LOW);
  assign busy_o     = (state_q != IDLE) && (state_q != PASS);
  assign done_o     = (state_q == PASS);

endmodule

// File: tb/tb_spi_lcd_init_ctrl.sv
// Directed bench: main instance plays CMD/DATA/DELAY/DATA/END; a second
// two-entry instance without END checks the index never runs past the table.
module tb_spi_lcd_init_ctrl;
  import spi_lcd_pkg::*;

  localparam tbl_entry_t [7:0] TblA = {
    mk_entry(OP_END,   8'h00), mk_entry(OP_END,   8'h00), mk_entry(OP_END, 8'h00),
    mk_entry(OP_END,   8'h00), mk_entry(OP_DATA,  8'h22), mk_entry(OP_DELAY, 8'h03),
    mk_entry(OP_DATA,  8'h05), mk_entry(OP_CMD,   8'h11)
  };
  localparam tbl_entry_t [1:0] TblB = {mk_entry(OP_DATA, 8'hB1), mk_entry(OP_CMD, 8'hA0)};

  logic clk = 1'b0;
  logic rst_n, start, cpu_valid, cpu_dc, cpu_ready, spi_valid, spi_ready, spi_idle;
  logic lcd_dc, lcd_rst_n, busy, done;
  logic [7:0] tbl_addr, cpu_data, spi_data;
  logic [EntryW-1:0] tbl_entry;

  logic start2, cpu_valid2, cpu_dc2, cpu_ready2, spi_valid2, spi_ready2, spi_idle2;
  logic lcd_dc2, lcd_rst_n2, busy2, done2;
  logic [7:0] tbl_addr2, cpu_data2, spi_data2;
  logic [EntryW-1:0] tbl_entry2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_a, t_b;

  always #5 clk = ~clk;

  // Free-running edge counter for handshake spacing.
  always @(posedge clk) cyc <= cyc + 1;

  spi_lcd_init_ctrl #(.NumEntries(8), .RstCycles(4), .DelayUnit(10)) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .start_i(start), .tbl_addr_o(tbl_addr),
    .tbl_entry_i(tbl_entry), .cpu_valid_i(cpu_valid), .cpu_data_i(cpu_data),
    .cpu_dc_i(cpu_dc), .cpu_ready_o(cpu_ready), .spi_valid_o(spi_valid),
    .spi_data_o(spi_data), .spi_ready_i(spi_ready), .spi_idle_i(spi_idle),
    .lcd_dc_o(lcd_dc), .lcd_rst_no(lcd_rst_n), .busy_o(busy), .done_o(done)
  );
  spi_lcd_init_rom #(.NumEntries(8), .Table(TblA)) rom (
    .tbl_addr_i(tbl_addr), .tbl_entry_o(tbl_entry)
  );

  spi_lcd_init_ctrl #(.NumEntries(2), .RstCycles(2), .DelayUnit(1)) dut2 (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .start_i(start2), .tbl_addr_o(tbl_addr2),
    .tbl_entry_i(tbl_entry2), .cpu_valid_i(cpu_valid2), .cpu_data_i(cpu_data2),
    .cpu_dc_i(cpu_dc2), .cpu_ready_o(cpu_ready2), .spi_valid_o(spi_valid2),
    .spi_data_o(spi_data2), .spi_ready_i(spi_ready2), .spi_idle_i(spi_idle2),
    .lcd_dc_o(lcd_dc2), .lcd_rst_no(lcd_rst_n2), .busy_o(busy2), .done_o(done2)
  );
  spi_lcd_init_rom #(.NumEntries(2), .Table(TblB)) rom2 (
    .tbl_addr_i(tbl_addr2), .tbl_entry_o(tbl_entry2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; spi_ready = 1'b1; spi_idle = 1'b1;
    cpu_valid = 1'b1; cpu_data = 8'hA5; cpu_dc = 1'b1;
    start2 = 1'b0; cpu_valid2 = 1'b0; cpu_data2 = 8'h00; cpu_dc2 = 1'b0;
    spi_ready2 = 1'b1; spi_idle2 = 1'b1;
    tick; tick;
    rst_n = 1'b1;
    tick;
    n_cmp++; if (spi_valid !== 1'b0) begin n_bad++; $display("FAIL rst_spi_valid: got %b want 0", spi_valid); end
    n_cmp++; if (spi_data !== 8'h00) begin n_bad++; $display("FAIL rst_spi_data: got %h want 00", spi_data); end
    n_cmp++; if (lcd_dc !== 1'b0) begin n_bad++; $display("FAIL rst_lcd_dc: got %b want 0", lcd_dc); end
    n_cmp++; if (lcd_rst_n !== 1'b1) begin n_bad++; $display("FAIL rst_lcd_rst_n: got %b want 1", lcd_rst_n); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_ready); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    n_cmp++; if (tbl_addr !== 8'd0) begin n_bad++; $display("FAIL rst_tbl_addr: got %0d want 0", tbl_addr); end
    spi_ready = 1'b0;
  endtask

  // Reset pulse: 4 low, then 4 high in RST_WAIT + FETCH + DRAIN before SEND.
  task automatic test_lcd_reset;
    int n;
    start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
    n = 0;
    while (lcd_rst_n === 1'b0 && n < 100) begin n++; tick; end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL rst_low_cycles: got %0d want 4", n); end
    n = 0;
    while (spi_valid !== 1'b1 && n < 100) begin n++; tick; end
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL rst_high_to_send: got %0d want 6", n); end
  endtask

  task automatic test_cmd_data;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (spi_valid !== 1'b1 || spi_data !== 8'h11 || lcd_dc !== 1'b0) begin
        n_bad++; $display("FAIL cmd_hold[%0d]: got v%b d%h dc%b want v1 d11 dc0", i, spi_valid, spi_data, lcd_dc);
      end
      tick;
    end
    spi_ready = 1'b1; spi_idle = 1'b0;
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL cpu_ready_in_init: got %b want 0", cpu_ready); end
    tick; spi_ready = 1'b0;
    n_cmp++; if (tbl_addr !== 8'd1 || spi_valid !== 1'b0) begin n_bad++; $display("FAIL after_cmd: got a%0d v%b want a1 v0", tbl_addr, spi_valid); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (spi_valid !== 1'b0 || lcd_dc !== 1'b0) begin
        n_bad++; $display("FAIL drain_hold[%0d]: got v%b dc%b want v0 dc0", i, spi_valid, lcd_dc);
      end
    end
    spi_idle = 1'b1; tick;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (spi_valid !== 1'b1 || spi_data !== 8'h05 || lcd_dc !== 1'b1) begin
        n_bad++; $display("FAIL data_hold[%0d]: got v%b d%h dc%b want v1 d05 dc1", i, spi_valid, spi_data, lcd_dc);
      end
      tick;
    end
    t_a = cyc; spi_ready = 1'b1; tick; spi_ready = 1'b0;
  endtask

  // 30 delay cycles + FETCH(delay) + FETCH(data) + one SEND cycle = 33.
  task automatic test_delay;
    int n;
    n = 0;
    while (spi_valid !== 1'b1 && n < 200) begin n++; tick; end
    n_cmp++;
    if (spi_data !== 8'h22 || lcd_dc !== 1'b1 || tbl_addr !== 8'd3) begin
      n_bad++; $display("FAIL post_delay_byte: got d%h dc%b a%0d want d22 dc1 a3", spi_data, lcd_dc, tbl_addr);
    end
    t_b = cyc; spi_ready = 1'b1; tick; spi_ready = 1'b0;
    n_cmp++; if (t_b - t_a !== 33) begin n_bad++; $display("FAIL delay_spacing: got %0d want 33", t_b - t_a); end
  endtask

  task automatic test_cpu_pass;
    int n;
    spi_ready = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL cpu_held_off: got %b want 0", cpu_ready); end
      n++; tick;
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL pass_flags: got done%b busy%b want 1 0", done, busy); end
    n_cmp++;
    if (spi_valid !== 1'b1 || spi_data !== 8'hA5 || lcd_dc !== 1'b1 || cpu_ready !== 1'b1) begin
      n_bad++; $display("FAIL pass_a5: got v%b d%h dc%b r%b want v1 dA5 dc1 r1", spi_valid, spi_data, lcd_dc, cpu_ready);
    end
    cpu_data = 8'h3C; cpu_dc = 1'b0; #1;
    n_cmp++; if (spi_data !== 8'h3C || lcd_dc !== 1'b0) begin n_bad++; $display("FAIL pass_comb: got d%h dc%b want d3C dc0", spi_data, lcd_dc); end
    spi_ready = 1'b0; cpu_valid = 1'b0; #1;
    n_cmp++; if (cpu_ready !== 1'b0 || spi_valid !== 1'b0) begin n_bad++; $display("FAIL pass_idle: got r%b v%b want 0 0", cpu_ready, spi_valid); end
    cpu_valid = 1'b1; cpu_data = 8'hA5; cpu_dc = 1'b1;
  endtask

  task automatic test_reset_mid_send;
    int n;
    start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL restart_flags: got done%b busy%b want 0 1", done, busy); end
    n = 0;
    while (lcd_rst_n === 1'b0 && n < 100) begin start = (n == 1); n++; tick; end
    start = 1'b0;
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL start_ignored: got %0d low cycles want 4", n); end
    n = 0;
    while (spi_valid !== 1'b1 && n < 100) begin n++; tick; end
    spi_ready = 1'b1; tick; spi_ready = 1'b0;
    n = 0;
    while (spi_valid !== 1'b1 && n < 100) begin n++; tick; end
    n_cmp++; if (tbl_addr !== 8'd1 || spi_data !== 8'h05) begin n_bad++; $display("FAIL second_send: got a%0d d%h want a1 d05", tbl_addr, spi_data); end
    rst_n = 1'b0; spi_ready = 1'b1; tick;
    n_cmp++;
    if (spi_valid !== 1'b0 || spi_data !== 8'h00 || lcd_dc !== 1'b0 || lcd_rst_n !== 1'b1 ||
        cpu_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tbl_addr !== 8'd0) begin
      n_bad++;
      $display("FAIL mid_send_reset: got v%b d%h dc%b rn%b r%b b%b dn%b a%0d want v0 d00 dc0 rn1 r0 b0 dn0 a0",
               spi_valid, spi_data, lcd_dc, lcd_rst_n, cpu_ready, busy, done, tbl_addr);
    end
    rst_n = 1'b1; spi_ready = 1'b0; tick;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (spi_valid !== 1'b1 && n < 100) begin n++; tick; end
    n_cmp++;
    if (tbl_addr !== 8'd0 || spi_data !== 8'h11 || lcd_dc !== 1'b0) begin
      n_bad++; $display("FAIL rerun_first: got a%0d d%h dc%b want a0 d11 dc0", tbl_addr, spi_data, lcd_dc);
    end
  endtask

  task automatic test_no_end;
    int n, nbytes;
    logic [7:0] maxa;
    logic [7:0] got [2];
    got[0] = 8'h00; got[1] = 8'h00;
    nbytes = 0; maxa = 8'd0;
    start2 = 1'b1; tick; start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 100) begin
      if (tbl_addr2 > maxa) maxa = tbl_addr2;
      if (spi_valid2 === 1'b1) begin
        if (nbytes < 2) got[nbytes] = spi_data2;
        nbytes++;
      end
      n++; tick;
    end
    n_cmp++; if (done2 !== 1'b1 || busy2 !== 1'b0) begin n_bad++; $display("FAIL no_end_pass: got done%b busy%b want 1 0", done2, busy2); end
    n_cmp++; if (nbytes !== 2) begin n_bad++; $display("FAIL no_end_count: got %0d want 2", nbytes); end
    n_cmp++; if (maxa !== 8'd1 || tbl_addr2 !== 8'd1) begin n_bad++; $display("FAIL no_end_addr: got max%0d now%0d want 1 1", maxa, tbl_addr2); end
    n_cmp++; if (got[0] !== 8'hA0 || got[1] !== 8'hB1) begin n_bad++; $display("FAIL no_end_bytes: got %h %h want A0 B1", got[0], got[1]); end
    n_cmp++;
    if (cpu_ready2 !== 1'b1 || lcd_rst_n2 !== 1'b1 || lcd_dc2 !== 1'b0) begin
      n_bad++; $display("FAIL no_end_pass_io: got r%b rn%b dc%b want 1 1 0", cpu_ready2, lcd_rst_n2, lcd_dc2);
    end
  endtask

  initial begin
    test_reset;
    test_lcd_reset;
    test_cmd_data;
    test_delay;
    test_cpu_pass;
    test_reset_mid_send;
    test_no_end;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
